weighted_rr_arbiter: RTL
========================

// Module: weighted_rr_arbiter
// PURPOSE
//  Packet-atomic, weighted round-robin arbiter for NoC switch/VC allocation.
//  Grants one of AGENTS_NUM requesters per cycle (one grant = one flit moved).
//  Holds the grant for the whole packet, and lets an owner send up to weight_i
//  packets per turn. The pointer then rotates to owner+1.
// PARAMETERS
//  AGENTS_NUM    4   number of requesters (>=2)
//  WEIGHT_W      4   width of per-agent weight field
//  STARVE_CYCLES 16  idle-owner timeout in cycles (used only with WRR_STARVE_EN)
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     reset, asynchronous, active-high
//  requests_i in   AGENTS_NUM            per-agent flit-ready request
//  tail_i     in   1                     granted flit this cycle is the packet tail
//  weights_i  in   AGENTS_NUM*WEIGHT_W   packets per turn; agent k = [k*WEIGHT_W +: WEIGHT_W]
//  grants_o   out  AGENTS_NUM            one-hot or zero grant (combinational)
//  owner_o    out  $clog2(AGENTS_NUM)    current/last owner index
//  locked_o   out  1                     1 while state != IDLE
//  starve_o   out  1                     1-cycle pulse on forced release (0 without macro)
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0, owner=0, cnt=0, starve cnt=0. grants_o=0 unless
//    a request is present (combinational); locked_o=0; starve_o=0.
//  - Reset is asynchronous and may hit mid-packet. The packet is abandoned
//    and the arbiter returns to IDLE.
//  - Grant has zero latency: grants_o depends on state regs and requests_i in
//    the same cycle. State updates on posedge clk.
//  - tail_i is sampled only when grants_o != 0.
//  - weight w_eff = (weights_i[k]==0) ? 1 : weights_i[k]. It is sampled when
//    a turn starts.
//  - IDLE:
//    - Pick the first requester k searching ptr, ptr+1, ... mod AGENTS_NUM.
//    - Set owner=k and cnt=w_eff(k).
//    - tail_i=0 -> PACKET.
//    - tail_i=1 -> cnt-1. If cnt-1==0: ptr=k+1, stay IDLE. Else -> TURN.
//    - No request -> no change.
//  - PACKET (mid-packet lock):
//    - grants_o = requests_i[owner] ? onehot(owner) : 0. Never grant another agent.
//    - On a granted tail: cnt-1. If 0: ptr=owner+1, -> IDLE. Else -> TURN.
//  - TURN (packet boundary, credits left):
//    - If requests_i[owner]: grant the owner, handled as in IDLE with cnt
//      continuing (not reloaded).
//    - Otherwise: release. Search from owner+1, excluding the owner, and grant
//      in the same cycle (no bubble). The new owner starts a fresh turn.
//      With no request: ptr=owner+1, -> IDLE.
//  - Index wrap: all index arithmetic is mod AGENTS_NUM. A non-power-of-2
//    AGENTS_NUM never yields an out-of-range index.
//  - Simultaneous events:
//    - A tail that exhausts cnt plus other pending requests: the next grant is
//      in the following cycle, from owner+1.
//    - A weight change mid-turn has no effect until the next turn.
// CONFIGURATION
//  WRR_STARVE_EN defined:
//    - In PACKET, count consecutive cycles with requests_i[owner]==0.
//      The count resets to 0 on any owner request.
//    - When the count reaches STARVE_CYCLES: force release (ptr=owner+1,
//      -> IDLE), pulse starve_o for 1 cycle, count=0.
//  WRR_STARVE_EN undefined:
//    - The lock is held indefinitely. starve_o is tied 0 and no counter is built.
// STRUCTURE
//  Package noc_arb_pkg:
//    - arb_state_t enum {IDLE, PACKET, TURN}
//    - localparam PTR_W = $clog2(AGENTS_NUM) (function of the parameter)
//    - function wrap_inc(idx, n)
//  Sub-module rr_priority_picker #(AGENTS_NUM):
//    - Combinational first-set search.
//    - Inputs: req, start ptr, exclude mask. Outputs: one-hot, index, valid.
//    - Used for both the IDLE and TURN-release searches.
// TESTING
//  1. Reset, req=4'b1010, weights=1, tail=1 every cycle
//     -> grants 0010,1000,0010,1000...; locked_o=0 throughout.
//  2. Agent0 w=3, req=4'b0011, tail=1 every cycle
//     -> grants 0001 x3, then 0010, then 0001 x3.
//  3. Agent2 granted with tail=0, then req[2] drops for 5 cycles while req=4'b1001
//     -> grants_o=0 for those 5 cycles; locked_o=1; agent2's tail resumes
//     and the next grant is 1000.
//  4. Agent1 in TURN (cnt=2), req[1] drops with req[3]=1
//     -> same-cycle grant 1000, owner_o=3, no idle cycle.
//  5. rst asserted mid-packet (state PACKET, owner=2)
//     -> locked_o=0 and ptr=0 immediately. After release, req=4'b1111 grants 0001.
//  6. WRR_STARVE_EN, STARVE_CYCLES=16: owner idles for 16 cycles mid-packet
//     -> starve_o pulses in cycle 16, the next grant goes to owner+1.
//     Without the macro, the lock holds for 100 cycles.

Source files
------------

// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared types and index helpers for the NoC weighted round-robin arbiter.
// Combinational helpers only; no state, no backpressure.
package noc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PACKET = 2'd1,
    TURN   = 2'd2
  } arb_state_t;

  localparam int AGENTS_NUM_DFLT = 4;
  localparam int PTR_W           = $clog2(AGENTS_NUM_DFLT);

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Increment modulo n without a divider; idx is always < n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Wires only; grants are combinational from the arbiter side.
interface weighted_rr_arbiter_if #(
  parameter int AGENTS_NUM = 4,
  parameter int WEIGHT_W   = 4
);
  import noc_arb_pkg::*;

  localparam int IDX_W = ptr_width(AGENTS_NUM);

  logic [AGENTS_NUM-1:0]          requests_i;
  logic                           tail_i;
  logic [AGENTS_NUM*WEIGHT_W-1:0] weights_i;
  logic [AGENTS_NUM-1:0]          grants_o;
  logic [IDX_W-1:0]               owner_o;
  logic                           locked_o;
  logic                           starve_o;

  modport master (
    output requests_i, tail_i, weights_i,
    input  grants_o, owner_o, locked_o, starve_o
  );

  modport slave (
    input  requests_i, tail_i, weights_i,
    output grants_o, owner_o, locked_o, starve_o
  );

endinterface

// File: rtl/weighted_rr_arbiter_picker.sv
// First-set search over req & ~excl starting at start, wrapping mod AGENTS_NUM.
// Purely combinational, zero latency; no backpressure.
module rr_priority_picker
  import noc_arb_pkg::*;
#(
  parameter int AGENTS_NUM = 4
) (
  input  logic [AGENTS_NUM-1:0]                 req,
  input  logic [ptr_width(AGENTS_NUM)-1:0]      start,
  input  logic [AGENTS_NUM-1:0]                 excl,
  output logic [AGENTS_NUM-1:0]                 onehot,
  output logic [ptr_width(AGENTS_NUM)-1:0]      idx,
  output logic                                  vld
);

  localparam int IDX_W = ptr_width(AGENTS_NUM);

  logic [IDX_W-1:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    vld    = 1'b0;
    k      = '0;
    for (int i = 0; i < AGENTS_NUM; i++) begin
      // Modulo keeps non-power-of-2 agent counts inside the valid range.
      k = IDX_W'((int'(start) + i) % AGENTS_NUM);
      if (!vld && req[k] && !excl[k]) begin
        vld       = 1'b1;
        onehot[k] = 1'b1;
        idx       = k;
      end
    end
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Packet-atomic weighted round-robin arbiter; grants are zero-latency from state + requests.
// Owner holds the grant per packet, up to w_eff packets per turn; optional WRR_STARVE_EN idle-owner release.
module weighted_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int AGENTS_NUM    = 4,
  parameter int WEIGHT_W      = 4,
  parameter int STARVE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  weighted_rr_arbiter_if.slave  bus
);

  localparam int IDX_W = ptr_width(AGENTS_NUM);

  arb_state_t          state, nxt_state;
  logic [IDX_W-1:0]    ptr, nxt_ptr;
  logic [IDX_W-1:0]    owner, nxt_owner;
  logic [WEIGHT_W-1:0] cnt, nxt_cnt;

  logic [AGENTS_NUM-1:0] grants;
  logic [AGENTS_NUM-1:0] owner_oh;
  logic                  owner_req;
  logic                  starve_pulse;

  logic [WEIGHT_W-1:0] w_eff [AGENTS_NUM];

  logic [IDX_W-1:0]      pick_start;
  logic [AGENTS_NUM-1:0] pick_excl;
  logic [AGENTS_NUM-1:0] pick_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld;

  logic                take;
  logic [IDX_W-1:0]    take_idx;
  logic [WEIGHT_W-1:0] take_cnt;
  logic [WEIGHT_W-1:0] cnt_left;
  logic [IDX_W-1:0]    owner_inc;
  logic [IDX_W-1:0]    take_inc;

  // A zero weight still grants one packet per turn.
  always_comb begin
    for (int a = 0; a < AGENTS_NUM; a++) begin
      w_eff[a] = (bus.weights_i[a*WEIGHT_W +: WEIGHT_W] == '0)
               ? WEIGHT_W'(1) : bus.weights_i[a*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign owner_oh  = AGENTS_NUM'(1) << owner;
  assign owner_req = bus.requests_i[owner];
  assign owner_inc = IDX_W'(wrap_inc(int'(owner), AGENTS_NUM));

  // One picker serves both searches: from ptr in IDLE, from owner+1 (owner excluded) on TURN release.
  assign pick_start = (state == TURN) ? owner_inc : ptr;
  assign pick_excl  = (state == TURN) ? owner_oh  : '0;

  rr_priority_picker #(
    .AGENTS_NUM (AGENTS_NUM)
  ) u_picker (
    .req    (bus.requests_i),
    .start  (pick_start),
    .excl   (pick_excl),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .vld    (pick_vld)
  );

`ifdef WRR_STARVE_EN
  localparam int STARVE_W = $clog2(STARVE_CYCLES + 1);
  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_hit;

  assign starve_hit = (state == PACKET) && !owner_req
                   && (starve_cnt == STARVE_W'(STARVE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == PACKET && !owner_req && !starve_hit) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  logic starve_hit;
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    nxt_state    = state;
    nxt_ptr      = ptr;
    nxt_owner    = owner;
    nxt_cnt      = cnt;
    grants       = '0;
    starve_pulse = 1'b0;
    take         = 1'b0;
    take_idx     = owner;
    take_cnt     = cnt;
    cnt_left     = '0;
    take_inc     = '0;

    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          take     = 1'b1;
          take_idx = pick_idx;
          take_cnt = w_eff[pick_idx];
        end
      end
      PACKET: begin
        if (owner_req) begin
          take = 1'b1;
        end else if (starve_hit) begin
          starve_pulse = 1'b1;
          nxt_ptr      = owner_inc;
          nxt_cnt      = '0;
          nxt_state    = IDLE;
        end
      end
      TURN: begin
        if (owner_req) begin
          take = 1'b1;
        end else if (pick_vld) begin
          take     = 1'b1;
          take_idx = pick_idx;
          take_cnt = w_eff[pick_idx];
        end else begin
          nxt_ptr   = owner_inc;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase

    // Shared grant path: start or continue a turn with take_cnt packets left.
    if (take) begin
      grants    = AGENTS_NUM'(1) << take_idx;
      nxt_owner = take_idx;
      cnt_left  = take_cnt - WEIGHT_W'(1);
      take_inc  = IDX_W'(wrap_inc(int'(take_idx), AGENTS_NUM));
      if (!bus.tail_i) begin
        nxt_cnt   = take_cnt;
        nxt_state = PACKET;
      end else if (cnt_left == '0) begin
        nxt_cnt   = '0;
        nxt_ptr   = take_inc;
        nxt_state = IDLE;
      end else begin
        nxt_cnt   = cnt_left;
        nxt_state = TURN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      ptr   <= nxt_ptr;
      owner <= nxt_owner;
      cnt   <= nxt_cnt;
    end
  end

  assign bus.grants_o = grants;
  assign bus.owner_o  = owner;
  assign bus.locked_o = (state != IDLE);
  assign bus.starve_o = starve_pulse;

endmodule
